// File: rtl/noc_flit_injector.sv
// Drains {addr,data} FIFO entries into head+tail flit pairs; pkt_count is built only with NOC_INJ_PKT_COUNT_EN.
// Pop to head valid in 2 cycles, one packet per 4 cycles; flit_ready low freezes the presented flit.
module noc_flit_injector #(
    parameter int COORD_W = 4,
    parameter int NODE_X  = 0,
    parameter int NODE_Y  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] fifo_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [33:0] flit_out,
    output logic        flit_valid,
    input  logic        flit_ready,
    output logic        busy,
    output logic [15:0] pkt_count
);

    typedef enum logic [1:0] {IDLE, FETCH, HEAD, TAIL} state_e;

    // Header source fields are always 4 bits wide regardless of COORD_W.
    localparam logic [COORD_W-1:0] NODE_X_W = COORD_W'(NODE_X);
    localparam logic [COORD_W-1:0] NODE_Y_W = COORD_W'(NODE_Y);
    localparam logic [3:0]         SRC_X    = 4'(NODE_X_W);
    localparam logic [3:0]         SRC_Y    = 4'(NODE_Y_W);

    state_e      state_q;
    logic [63:0] hold_q;
    logic        unused_hold;

    assign unused_hold = ^hold_q[55:48];
    assign fifo_rd_en  = rst_n && (state_q == IDLE) && !fifo_empty;
    assign busy        = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            case (state_q)
                IDLE:    if (!fifo_empty) state_q <= FETCH;
                FETCH: begin
                    hold_q  <= fifo_data;
                    state_q <= HEAD;
                end
                HEAD:    if (flit_ready) state_q <= TAIL;
                TAIL:    if (flit_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Flit outputs decode only registered state, so they cannot glitch on input changes.
    always_comb begin
        flit_valid = 1'b0;
        flit_out   = '0;
        case (state_q)
            HEAD: begin
                flit_valid = 1'b1;
                flit_out   = {2'b10, hold_q[63:60], hold_q[59:56], SRC_X, SRC_Y, hold_q[47:32]};
            end
            TAIL: begin
                flit_valid = 1'b1;
                flit_out   = {2'b01, hold_q[31:0]};
            end
            default: ;
        endcase
    end

`ifdef NOC_INJ_PKT_COUNT_EN
    logic        tail_acc;
    logic [15:0] pkt_cnt_q;
    logic [15:0] pkt_cnt_d;

    assign tail_acc  = (state_q == TAIL) && flit_ready;
    assign pkt_cnt_d = pkt_cnt_q + 16'(tail_acc);
    assign pkt_count = pkt_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) pkt_cnt_q <= '0;
        else        pkt_cnt_q <= pkt_cnt_d;
    end
`else
    assign pkt_count = 16'h0000;
`endif

endmodule

// File: tb/tb_noc_flit_injector.sv
// Bench for noc_flit_injector: FIFO model, flit scoreboard, fixed vectors, hand sequences and random traffic.
module tb_noc_flit_injector;

    localparam logic [3:0] SRC_X = 4'h3;
    localparam logic [3:0] SRC_Y = 4'h9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] fifo_data = '0;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [33:0] flit_out;
    logic        flit_valid;
    logic        flit_ready;
    logic        busy;
    logic [15:0] pkt_count;

    noc_flit_injector #(.COORD_W(4), .NODE_X(3), .NODE_Y(9)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .flit_out   (flit_out),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .busy       (busy),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // FIFO model: entries written by the stimulus, read data valid the cycle after a pop.
    logic [63:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int cyc    = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    function automatic logic [33:0] mk_head(input logic [63:0] e);
        logic [31:0] a;
        a = e[63:32];
        return {1'b1, 1'b0, a[31:28], a[27:24], SRC_X, SRC_Y, a[15:0]};
    endfunction

    function automatic logic [33:0] mk_tail(input logic [63:0] e);
        return {1'b0, 1'b1, e[31:0]};
    endfunction

    function automatic logic [15:0] exp_pc(input int n);
        logic [15:0] r;
        r = 16'(n);
`ifndef NOC_INJ_PKT_COUNT_EN
        r = 16'h0000;
`endif
        return r;
    endfunction

    // Scoreboard and protocol monitor, sampled on the falling edge.
    logic [33:0] exp_q[$];
    int          pop_cyc[$];
    int          n_acc = 0, sb_err = 0, stab_err = 0, zero_err = 0, rd_err = 0;
    logic        prev_vld = 1'b0, prev_rdy = 1'b0, prev_rst = 1'b0;
    logic [33:0] prev_out = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (flit_valid && flit_ready) begin
                n_acc++;
                if (exp_q.size() == 0) sb_err++;
                else begin
                    if (flit_out !== exp_q[0]) sb_err++;
                    void'(exp_q.pop_front());
                end
            end
            if (fifo_rd_en) begin
                pop_cyc.push_back(cyc);
                exp_q.push_back(mk_head(mem[rd_ptr]));
                exp_q.push_back(mk_tail(mem[rd_ptr]));
            end
        end
        if (prev_rst && prev_vld && !prev_rdy && (!flit_valid || flit_out !== prev_out)) stab_err++;
        if (!flit_valid && flit_out !== '0) zero_err++;
        if (fifo_rd_en && (busy || !rst_n || fifo_empty)) rd_err++;
        prev_vld = flit_valid;
        prev_rdy = flit_ready;
        prev_rst = rst_n;
        prev_out = flit_out;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] e);
        mem[wr_ptr] = e;
        wr_ptr++;
    endtask

    task automatic wait_idle(input string nm, input int max_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || !fifo_empty) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " drain timeout"}, {63'd0, busy || !fifo_empty}, 64'd0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [63:0] entry;
        logic [33:0] head;
        logic [33:0] tail;
    } vec_t;

    vec_t        vt [5];
    int          pk, exp_acc, pops0, p0, n_push;
    logic [63:0] e, e2;

    initial begin
        vt[0] = '{64'hA500_1234_DEAD_BEEF, {2'b10, 32'hA539_1234}, {2'b01, 32'hDEAD_BEEF}};
        vt[1] = '{64'h1FFF_0000_0000_0000, {2'b10, 32'h1F39_0000}, {2'b01, 32'h0000_0000}};
        vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, {2'b10, 32'hFF39_FFFF}, {2'b01, 32'hFFFF_FFFF}};
        vt[3] = '{64'h0000_0000_0000_0001, {2'b10, 32'h0039_0000}, {2'b01, 32'h0000_0001}};
        vt[4] = '{64'h7C5A_8001_1357_9BDF, {2'b10, 32'h7C39_8001}, {2'b01, 32'h1357_9BDF}};

        rst_n = 1'b0;
        flit_ready = 1'b0;
        pk = 0;
        exp_acc = 0;
        repeat (2) @(posedge clk);
        #1;
        push(64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        chk("reset rd_en", {63'd0, fifo_rd_en}, 0);
        chk("reset flit_valid", {63'd0, flit_valid}, 0);
        chk("reset flit_out", {30'd0, flit_out}, 0);
        chk("reset busy", {63'd0, busy}, 0);
        chk("reset pkt_count", {48'd0, pkt_count}, 0);
        @(posedge clk); #1;
        wr_ptr--;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle after reset", {61'd0, fifo_rd_en, flit_valid, busy}, 0);
        @(posedge clk); #1;

        flit_ready = 1'b1;
        foreach (vt[i]) begin
            push(vt[i].entry);
            @(negedge clk);
            chk($sformatf("vec%0d c0 pop", i), {62'd0, fifo_rd_en, busy}, 64'b10);
            @(negedge clk);
            chk($sformatf("vec%0d c1 fetch", i), {61'd0, fifo_rd_en, flit_valid, busy}, 64'b001);
            @(negedge clk);
            chk($sformatf("vec%0d c2 head", i), {29'd0, flit_valid, flit_out}, {29'd0, 1'b1, vt[i].head});
            @(negedge clk);
            chk($sformatf("vec%0d c3 tail", i), {29'd0, flit_valid, flit_out}, {29'd0, 1'b1, vt[i].tail});
            @(negedge clk);
            pk++;
            exp_acc += 2;
            chk($sformatf("vec%0d c4 idle", i), {61'd0, fifo_rd_en, flit_valid, busy}, 0);
            chk($sformatf("vec%0d pkt_count", i), {48'd0, pkt_count}, {48'd0, exp_pc(pk)});
            @(posedge clk); #1;
        end

        flit_ready = 1'b0;
        e  = 64'h4B2E_77AA_C0FF_EE00;
        e2 = 64'h2D61_0042_0BAD_F00D;
        pops0 = pop_cyc.size();
        push(e);
        @(negedge clk);
        chk("bp pop", {63'd0, fifo_rd_en}, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp head hold %0d", k), {28'd0, fifo_rd_en, flit_valid, flit_out}, {28'd0, 2'b01, mk_head(e)});
            @(posedge clk); #1;
            if (k == 1) push(e2);
        end
        flit_ready = 1'b1;
        @(negedge clk);
        chk("bp head accept", {29'd0, flit_valid, flit_out}, {29'd0, 1'b1, mk_head(e)});
        @(posedge clk); #1;
        flit_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp tail hold %0d", k), {28'd0, fifo_rd_en, flit_valid, flit_out}, {28'd0, 2'b01, mk_tail(e)});
            @(posedge clk); #1;
        end
        flit_ready = 1'b1;
        @(negedge clk);
        chk("bp tail accept", {29'd0, flit_valid, flit_out}, {29'd0, 1'b1, mk_tail(e)});
        @(posedge clk); #1;
        chk("bp single pop", pop_cyc.size(), pops0 + 1);
        pk++;
        chk("bp pkt_count", {48'd0, pkt_count}, {48'd0, exp_pc(pk)});
        wait_idle("bp second packet", 50);
        pk++;
        exp_acc += 4;

        p0 = pop_cyc.size();
        for (int k = 0; k < 3; k++) push({$urandom, $urandom});
        wait_idle("b2b", 50);
        chk("b2b pops", pop_cyc.size() - p0, 3);
        chk("b2b spacing 1", pop_cyc[p0 + 1] - pop_cyc[p0], 4);
        chk("b2b spacing 2", pop_cyc[p0 + 2] - pop_cyc[p0 + 1], 4);
        pk += 3;
        exp_acc += 6;
        chk("b2b pkt_count", {48'd0, pkt_count}, {48'd0, exp_pc(pk)});

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("empty %0d", k), {61'd0, fifo_rd_en, flit_valid, busy}, 0);
        end
        @(posedge clk); #1;

        n_push = 0;
        for (int k = 0; k < 200; k++) begin
            flit_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                push({$urandom, $urandom});
                n_push++;
            end
            @(posedge clk); #1;
        end
        flit_ready = 1'b1;
        wait_idle("random", 1000);
        pk += n_push;
        exp_acc += 2 * n_push;
        chk("random pkt_count", {48'd0, pkt_count}, {48'd0, exp_pc(pk)});
        chk("random scoreboard", sb_err, 0);

        e = 64'h9E00_5A5A_CAFE_F00D;
        push(e);
        @(negedge clk);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst-mid head", {29'd0, flit_valid, flit_out}, {29'd0, 1'b1, mk_head(e)});
        @(posedge clk); #1;
        flit_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst-mid tail held", {29'd0, flit_valid, flit_out}, {29'd0, 1'b1, mk_tail(e)});
        @(posedge clk); #1;
        rst_n = 1'b0;
        push(64'h3300_0777_0000_ABCD);
        @(negedge clk);
        chk("rst-mid rd_en in reset", {63'd0, fifo_rd_en}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst-mid valid dropped", {29'd0, flit_valid, flit_out}, 0);
        chk("rst-mid restart", {61'd0, fifo_rd_en, busy, 1'b0}, 64'b100);
        chk("rst-mid pkt_count cleared", {48'd0, pkt_count}, 0);
        @(posedge clk); #1;
        flit_ready = 1'b1;
        exp_acc += 3;
        wait_idle("rst-mid next", 50);
        pk = 1;
        chk("rst-mid pkt_count", {48'd0, pkt_count}, {48'd0, exp_pc(pk)});

`ifdef NOC_INJ_PKT_COUNT_EN
        force dut.pkt_cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.pkt_cnt_q;
        @(negedge clk);
        chk("wrap preset", {48'd0, pkt_count}, 64'hFFFF);
        @(posedge clk); #1;
        push(64'h5500_0001_0000_0002);
        wait_idle("wrap", 50);
        exp_acc += 2;
        chk("wrap to zero", {48'd0, pkt_count}, 0);
`endif

        chk("scoreboard order/data", sb_err, 0);
        chk("scoreboard drained", exp_q.size(), 0);
        chk("accepted flit count", n_acc, exp_acc);
        chk("backpressure stability", stab_err, 0);
        chk("flit_out zero when idle", zero_err, 0);
        chk("rd_en only in idle", rd_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: bench did not reach its summary");
        $fatal(1);
    end

endmodule
